pzbcm_slicer_arbiter: RTL
=========================

# pzbcm_slicer_arbiter

N-to-1 valid/ready stream arbiter that shares one registered output slice between several requesters. Each cycle it picks one valid requester, by round-robin or fixed priority, and accepts its beat into a two-entry full-bandwidth output buffer. The buffer emits the beat together with the winning requester index. It sits in front of shared pipelines and slicer chains wherever several producers feed one consumer.

## Interface
- REQUESTS, 2: number of requesters; must be ≥ 2.
- WIDTH, 1: data width used when TYPE is left at its default.
- TYPE, logic [WIDTH-1:0]: data type carried; W = $bits(TYPE).
- ROUND_ROBIN, 1: 1 selects round-robin, 0 selects fixed priority (lowest index wins).
- USE_RESET, 1: 1 resets the data/index storage to 0; 0 leaves it unreset (control state is always reset).
- IDX_W (localparam) = max(1, $clog2(REQUESTS)).

Ports:
- i_clk  in  1  clock; all state on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  REQUESTS  per-requester valid.
- o_ready  out  REQUESTS  per-requester ready; at most one bit set.
- i_data  in  REQUESTS×TYPE  per-requester data (unpacked array).
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_data  out  TYPE  output data.
- o_index  out  IDX_W  requester index of the output beat.

## Operation
- Storage: two-entry FIFO (entry slots plus a 2-bit count, 0..2).
- Output side:
  - o_valid = (count != 0).
  - o_data / o_index = head entry.
  - Output pop when o_valid && i_ready.
- Acceptance:
  - full = (count == 2), a registered signal.
  - o_ready[i] = grant[i] && !full.
  - Push when any i_valid && !full. The granted requester's data and index go into the tail slot.
- Arbitration is combinational from i_valid and the priority state:
  - grant is one-hot, and all zero when no i_valid is set.
  - Fixed priority: the lowest set index wins.
  - Round-robin: search starts at ptr+1 modulo REQUESTS and wraps; the first set index wins.
- ptr update: ptr holds the index of the last accepted requester. It updates only on a push; a grant with no push (full) leaves ptr unchanged. ptr is unused when ROUND_ROBIN=0.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together (count = 1): stays 1, and head advances to the new beat.
  - Push with count = 2 cannot occur, because o_ready is 0.
- Order: beats leave in acceptance order. Nothing is dropped or duplicated.
- Requester rules: i_valid must not depend on o_ready. Once i_valid is raised it must stay high, with stable i_data, until accepted.
- The arbiter does not hold a grant for a waiting requester. Under round-robin, a requester that keeps valid asserted is served within REQUESTS accepted beats.
- Reset (asynchronous, any time, including mid-transfer):
  - count = 0, o_valid = 0, and o_ready = 0 on all bits while in reset.
  - ptr = REQUESTS−1, so requester 0 has first priority.
  - Stored data/index = 0 if USE_RESET=1.
  - Beats held in the buffer are discarded.

## Timing
- Latency: a beat accepted at edge k appears on o_valid/o_data/o_index after edge k, i.e. in cycle k+1.
- Throughput: one beat per cycle while i_ready=1 and some i_valid=1.
- Backpressure: with i_ready=0, at most two beats are accepted, then o_ready = 0 from the cycle after the second push.
- Recovery: o_ready re-asserts in the cycle after the first pop.
- Combinational paths:
  - i_valid → o_ready exists.
  - i_ready → o_ready does not exist (full is registered).
  - No combinational path from any input to o_valid, o_data or o_index.

## Test plan
- Reset: hold i_rst_n=0 with all i_valid=1 → o_valid=0 and o_ready=0. After release, the first accepted beat is from requester 0 and o_index=0 in the next cycle.
- Round-robin, REQUESTS=4, all valid, i_ready=1 → o_index sequence 0,1,2,3,0,1 at one beat per cycle, with data matching each requester's stream in order.
- Fixed priority, requesters 1 and 3 valid → index 1 served every cycle. After requester 1 drops, index 3 is served.
- Backpressure: all valid with i_ready=0 for 5 cycles → exactly 2 beats accepted, o_ready=0 for cycles 3–5, and o_data stable. On i_ready=1, beats drain in order and acceptance resumes one cycle later, with no loss.
- Round-robin fairness: requester 2 continuously valid, others toggling randomly → requester 2 is accepted at least once in every 4 accepted beats.
- Mid-operation reset: count=2 and i_ready=0, then assert i_rst_n=0 asynchronously mid-cycle → o_valid drops immediately. After release, no stale beat is emitted and priority restarts at 0.

Source files
------------

// File: rtl/pzbcm_slicer_arbiter.sv
// N-to-1 valid/ready arbiter feeding a two-entry registered output slice.
// Each output beat carries the index of the requester that produced it.
module pzbcm_slicer_arbiter #(
  parameter int   REQUESTS    = 2,
  parameter int   WIDTH       = 1,
  parameter type  TYPE        = logic [WIDTH-1:0],
  parameter bit   ROUND_ROBIN = 1'b1,
  parameter bit   USE_RESET   = 1'b1,
  localparam int  IDX_W       = (REQUESTS > 2) ? $clog2(REQUESTS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [REQUESTS-1:0] i_valid,
  output logic [REQUESTS-1:0] o_ready,
  input  TYPE                 i_data [REQUESTS],
  output logic                o_valid,
  input  logic                i_ready,
  output TYPE                 o_data,
  output logic [IDX_W-1:0]    o_index
);

  logic [REQUESTS-1:0] grant;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    ptr_q;
  logic [1:0]          count_q;
  logic [1:0]          count_next;
  logic                head_q;
  logic                tail;
  logic                full;
  logic                push;
  logic                pop;
  TYPE                 data_q  [2];
  logic [IDX_W-1:0]    index_q [2];

  // Round-robin searches from the slot after the last accepted requester;
  // fixed priority simply scans from index 0.
  always_comb begin
    int unsigned cand;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < REQUESTS; k++) begin
      if (ROUND_ROBIN) begin
        cand = (32'(ptr_q) + 32'd1 + k) % 32'(REQUESTS);
      end else begin
        cand = k;
      end
      if (!found && i_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // full comes straight from the count register, so i_ready never reaches
  // o_ready combinationally; i_rst_n gating keeps o_ready low during reset.
  assign full    = (count_q == 2'd2);
  assign o_ready = grant & {REQUESTS{~full & i_rst_n}};
  assign push    = (|i_valid) & ~full & i_rst_n;
  assign pop     = (count_q != 2'd0) & i_ready;
  assign tail    = head_q ^ (count_q == 2'd1);

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      head_q  <= 1'b0;
      ptr_q   <= IDX_W'(REQUESTS - 1);
    end else begin
      count_q <= count_next;
      if (pop) begin
        head_q <= ~head_q;
      end
      if (push) begin
        ptr_q <= grant_idx;
      end
    end
  end

  if (USE_RESET) begin : g_store_rst
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int unsigned j = 0; j < 2; j++) begin
          data_q[j]  <= '0;
          index_q[j] <= '0;
        end
      end else if (push) begin
        data_q[tail]  <= i_data[grant_idx];
        index_q[tail] <= grant_idx;
      end
    end
  end else begin : g_store_nrst
    always_ff @(posedge i_clk) begin
      if (push) begin
        data_q[tail]  <= i_data[grant_idx];
        index_q[tail] <= grant_idx;
      end
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_data  = data_q[head_q];
  assign o_index = index_q[head_q];

endmodule
